// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment pattern table and scan state type
package seg7_pkg;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
  typedef enum logic {BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: hex nibble to active-high segment pattern (seg[0] = a)
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  assign pat = SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: multiplexes digits onto one segment bus with tear-free frame-synchronous shadow updates
module seg7_scan_scheduler
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 250,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  scan_state_t state, state_n;
  logic tick_d, edge_s, wrap, pending, blink_phase, vis, dp_n, blink_wrap;
  logic [IW-1:0] idx, idx_n;
  logic [BW-1:0] blink_cnt;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0] sh_en, sh_blink, sh_dp, an_n;
  logic [3:0] nib;
  logic [6:0] pat, seg_n;
  assign nib = sh_val[4*idx +: 4];
  seg7_decoder u_dec (.nib(nib), .pat(pat));
  always_comb begin
    edge_s = scan_tick & ~tick_d;
    wrap = edge_s & (idx == IW'(NUM_DIGITS - 1));
    idx_n = wrap ? '0 : idx + 1'b1;
    state_n = edge_s ? BLANK : DRIVE;
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    vis = sh_en[idx] & ~(sh_blink[idx] & blink_phase);
    an_n = edge_s ? {NUM_DIGITS{ACTIVE_LOW}}
         : state == BLANK ? (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{ACTIVE_LOW}} : an;
    seg_n = state == BLANK ? (vis ? pat : SEG_BLANK) ^ {7{ACTIVE_LOW}} : seg;
    dp_n = state == BLANK ? (vis & sh_dp[idx]) ^ ACTIVE_LOW : dp;
  end
  always_ff @(posedge clk)
    state <= rst ? BLANK : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_d <= 1'b0;
      idx <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      pending <= 1'b0;
      sh_val <= '0;
      sh_en <= '0;
      sh_blink <= '0;
      sh_dp <= '0;
      upd_ack <= 1'b0;
      frame_start <= 1'b0;
      an <= {NUM_DIGITS{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp <= ACTIVE_LOW;
    end else begin
      tick_d <= scan_tick;
      if (edge_s) begin
        idx <= idx_n;
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_phase ^ blink_wrap;
      end
      if (wrap & pending) begin
        sh_val <= digit_val;
        sh_en <= digit_en;
        sh_blink <= blink_mask;
        sh_dp <= dp_in;
      end
      pending <= (wrap & pending) ? 1'b0 : pending | (upd_req & ~upd_ack);
      upd_ack <= wrap & pending;
      frame_start <= wrap;
      an <= an_n;
      seg <= seg_n;
      dp <= dp_n;
    end
  end
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler: directed scan, handshake, blink, wide-tick and reset checks
module tb_seg7_scan_scheduler;
  logic clk = 1'b0, rst = 1'b1, scan_tick = 1'b0, upd_req = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0] digit_en = '0, blink_mask = '0, dp_in = '0, an;
  logic [6:0] seg;
  logic dp, upd_ack, frame_start;
  int checks = 0, failures = 0, ack_cnt = 0, fs_cnt = 0, ack_no_fs = 0;
  seg7_scan_scheduler #(.NUM_DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .digit_val(digit_val),
    .digit_en(digit_en), .blink_mask(blink_mask), .dp_in(dp_in), .upd_req(upd_req),
    .upd_ack(upd_ack), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (upd_ack === 1'b1) ack_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (upd_ack === 1'b1 && frame_start !== 1'b1) ack_no_fs++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic scan(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic dp_e, input bit drop);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    if (drop) upd_req = 1'b0;
    check({tag, "_off"}, 32'(an), 32'hF);
    @(negedge clk);
    check({tag, "_an"}, 32'(an), 32'(an_e));
    check({tag, "_seg"}, 32'(seg), 32'(seg_e));
    check({tag, "_dp"}, 32'(dp), 32'(dp_e));
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_ack", 32'(upd_ack), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    repeat (2) begin
      scan("idle1", 4'hD, 7'h7F, 1'b1, 1'b0);
      scan("idle2", 4'hB, 7'h7F, 1'b1, 1'b0);
      scan("idle3", 4'h7, 7'h7F, 1'b1, 1'b0);
      scan("idle0", 4'hE, 7'h7F, 1'b1, 1'b0);
    end
    check("idle_acks", 32'(ack_cnt), 32'd0);
    digit_val = 16'h4321;
    digit_en = 4'hF;
    upd_req = 1'b1;
    scan("ld1", 4'hD, 7'h7F, 1'b1, 1'b0);
    scan("ld2", 4'hB, 7'h7F, 1'b1, 1'b0);
    scan("ld3", 4'h7, 7'h7F, 1'b1, 1'b0);
    scan("ld0", 4'hE, 7'h79, 1'b1, 1'b1);
    check("ld_acks", 32'(ack_cnt), 32'd1);
    scan("run1", 4'hD, 7'h24, 1'b1, 1'b0);
    scan("run2", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("run3", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("run0", 4'hE, 7'h79, 1'b1, 1'b0);
    digit_val = 16'hFFFF;
    scan("tear1", 4'hD, 7'h24, 1'b1, 1'b0);
    scan("tear2", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("tear3", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("tear0", 4'hE, 7'h79, 1'b1, 1'b0);
    check("tear_acks", 32'(ack_cnt), 32'd1);
    digit_val = 16'h4321;
    blink_mask = 4'b0001;
    upd_req = 1'b1;
    scan("bl_ld1", 4'hD, 7'h24, 1'b1, 1'b0);
    scan("bl_ld2", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("bl_ld3", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("bl_ld0", 4'hE, 7'h79, 1'b1, 1'b1);
    check("bl_acks", 32'(ack_cnt), 32'd2);
    scan("blA1", 4'hD, 7'h24, 1'b1, 1'b0);
    scan("blA2", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("blA3", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("blA0", 4'hE, 7'h7F, 1'b1, 1'b0);
    scan("blB1", 4'hD, 7'h24, 1'b1, 1'b0);
    scan("blB2", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("blB3", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("blB0", 4'hE, 7'h79, 1'b1, 1'b0);
    scan_tick = 1'b1;
    repeat (10) @(negedge clk);
    scan_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("wide_an", 32'(an), 32'hD);
    check("wide_seg", 32'(seg), 32'h24);
    scan("wide_next", 4'hB, 7'h30, 1'b1, 1'b0);
    digit_val = 16'h8888;
    blink_mask = 4'b0000;
    upd_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_an", 32'(an), 32'hF);
    check("mid_seg", 32'(seg), 32'h7F);
    upd_req = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    scan("mid1", 4'hD, 7'h7F, 1'b1, 1'b0);
    scan("mid2", 4'hB, 7'h7F, 1'b1, 1'b0);
    scan("mid3", 4'h7, 7'h7F, 1'b1, 1'b0);
    scan("mid0", 4'hE, 7'h7F, 1'b1, 1'b0);
    check("mid_acks", 32'(ack_cnt), 32'd2);
    digit_val = 16'h4321;
    dp_in = 4'b0010;
    upd_req = 1'b1;
    scan("bb1", 4'hD, 7'h7F, 1'b1, 1'b0);
    scan("bb2", 4'hB, 7'h7F, 1'b1, 1'b0);
    scan("bb3", 4'h7, 7'h7F, 1'b1, 1'b0);
    scan("bb0", 4'hE, 7'h79, 1'b1, 1'b0);
    scan("bb5", 4'hD, 7'h24, 1'b0, 1'b0);
    scan("bb6", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("bb7", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("bb8", 4'hE, 7'h79, 1'b1, 1'b1);
    scan("bb9", 4'hD, 7'h24, 1'b0, 1'b0);
    scan("bb10", 4'hB, 7'h30, 1'b1, 1'b0);
    scan("bb11", 4'h7, 7'h19, 1'b1, 1'b0);
    scan("bb12", 4'hE, 7'h79, 1'b1, 1'b0);
    check("bb_acks", 32'(ack_cnt), 32'd4);
    check("ack_with_fs", 32'(ack_no_fs), 32'd0);
    check("fs_count", 32'(fs_cnt), 32'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
